// File: rtl/wb_tlc_pkg.sv
// Shared types and helpers for the WB/TLC clock-domain-crossing blocks.
package wb_tlc_pkg;

  localparam int c_GRAY_FN_WIDTH   = 32;
  localparam int c_SYNC_STAGES_DEF = 2;

  typedef enum logic {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_e;

  function automatic logic [c_GRAY_FN_WIDTH-1:0] bin2gray(input logic [c_GRAY_FN_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [c_GRAY_FN_WIDTH-1:0] gray2bin(input logic [c_GRAY_FN_WIDTH-1:0] gray);
    logic [c_GRAY_FN_WIDTH-1:0] bin;
    bin = gray;
    for (int i = c_GRAY_FN_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_sync.sv
// Carries a binary counter from src_clk_i to dst_clk_i through a Gray-coded flop chain.
module gray_ptr_sync
  import wb_tlc_pkg::*;
#(
  parameter int c_WIDTH  = 11,
  parameter int c_STAGES = c_SYNC_STAGES_DEF
) (
  input  logic               src_clk_i,
  input  logic               dst_clk_i,
  input  logic               rst_i,
  input  logic [c_WIDTH-1:0] bin_i,
  output logic [c_WIDTH-1:0] bin_o
);

  logic [c_WIDTH-1:0] gray_d;
  logic [c_WIDTH-1:0] gray_q;
  logic [c_WIDTH-1:0] sync_q [c_STAGES];

  // Source-side Gray encode so only one bit toggles per increment.
  always_comb begin
    gray_d = c_WIDTH'(bin2gray(c_GRAY_FN_WIDTH'(bin_i)));
  end

  // Launch register in the source domain.
  always_ff @(posedge src_clk_i or posedge rst_i) begin
    if (rst_i) gray_q <= '0;
    else       gray_q <= gray_d;
  end

  // Synchroniser chain in the destination domain.
  always_ff @(posedge dst_clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < c_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_q;
      for (int i = 1; i < c_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign bin_o = c_WIDTH'(gray2bin(c_GRAY_FN_WIDTH'(sync_q[c_STAGES-1])));

endmodule

// File: rtl/async_pkt_fifo_v2.sv
// Dual-clock packet FIFO: reader only ever sees EOP-committed packets.
// Write-side state machine:
//   state     | meaning
//   WR_ACCEPT | beats are stored while space remains
//   WR_DROP   | overflowed mid-packet; beats ignored until EOP, then rewind to last commit
module async_pkt_fifo_v2
  import wb_tlc_pkg::*;
#(
  parameter int c_DATA_WIDTH  = 10,
  parameter int c_ADDR_WIDTH  = 10,
  parameter int c_AFULL_FLAG  = 100,
  parameter int c_AEMPTY_FLAG = 10,
  parameter int c_SYNC_STAGES = c_SYNC_STAGES_DEF
) (
  input  logic                    WrClock,
  input  logic                    RdClock,
  input  logic                    Reset,
  input  logic [c_DATA_WIDTH-1:0] Data,
  input  logic                    WrEn,
  input  logic                    WrEop,
  input  logic                    WrAbort,
  output logic                    Full,
  output logic                    AlmostFull,
  output logic                    WrDropped,
  input  logic                    RdEn,
  output logic [c_DATA_WIDTH-1:0] Q,
  output logic                    RdEop,
  output logic                    QValid,
  output logic                    Empty,
  output logic                    AlmostEmpty,
  output logic [c_ADDR_WIDTH:0]   PktCount
);

  localparam int c_PW    = c_ADDR_WIDTH + 1;
  localparam int c_DEPTH = 1 << c_ADDR_WIDTH;
  localparam int c_MW    = c_DATA_WIDTH + 1;

  typedef logic [c_PW-1:0] ptr_t;
  localparam ptr_t c_PTR_ONE = ptr_t'(1);
  localparam ptr_t c_FULL_XOR = ptr_t'(1) << c_ADDR_WIDTH;

  logic [c_MW-1:0] mem_q [c_DEPTH];
  logic            mem_we;

  wr_state_e wr_state_q, wr_state_d;
  ptr_t      wr_addr_q, wr_addr_d, wr_commit_q, wr_commit_d, wr_pkt_cnt_q, wr_pkt_cnt_d;
  ptr_t      rd_sync, wr_level;
  logic      wr_dropped_q, wr_dropped_d, afull_q, afull_d, full;

  ptr_t            rd_addr_q, rd_addr_d, rd_pkt_cnt_q, rd_pkt_cnt_d;
  ptr_t            commit_sync, pkt_sync, rd_level;
  logic [c_MW-1:0] rd_word_q;
  logic            qvalid_q, aempty_q, aempty_d, empty, rd_fire;

  gray_ptr_sync #(.c_WIDTH(c_PW), .c_STAGES(c_SYNC_STAGES)) u_sync_commit (
    .src_clk_i(WrClock), .dst_clk_i(RdClock), .rst_i(Reset), .bin_i(wr_commit_q), .bin_o(commit_sync)
  );
  gray_ptr_sync #(.c_WIDTH(c_PW), .c_STAGES(c_SYNC_STAGES)) u_sync_pkt (
    .src_clk_i(WrClock), .dst_clk_i(RdClock), .rst_i(Reset), .bin_i(wr_pkt_cnt_q), .bin_o(pkt_sync)
  );
  gray_ptr_sync #(.c_WIDTH(c_PW), .c_STAGES(c_SYNC_STAGES)) u_sync_rd (
    .src_clk_i(RdClock), .dst_clk_i(WrClock), .rst_i(Reset), .bin_i(rd_addr_q), .bin_o(rd_sync)
  );

  assign full = (wr_addr_q ^ rd_sync) == c_FULL_XOR;

  // Write-side next state: abort beats everything, then drop handling, then normal store.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_addr_d    = wr_addr_q;
    wr_commit_d  = wr_commit_q;
    wr_pkt_cnt_d = wr_pkt_cnt_q;
    wr_dropped_d = 1'b0;
    mem_we       = 1'b0;
    if (WrAbort) begin
      wr_addr_d    = wr_commit_q;
      wr_state_d   = WR_ACCEPT;
      wr_dropped_d = (wr_addr_q != wr_commit_q) || (wr_state_q == WR_DROP);
    end else if (WrEn) begin
      if (wr_state_q == WR_DROP) begin
        if (WrEop) begin
          wr_addr_d    = wr_commit_q;
          wr_state_d   = WR_ACCEPT;
          wr_dropped_d = 1'b1;
        end
      end else if (full) begin
        if (WrEop) begin
          wr_addr_d    = wr_commit_q;
          wr_dropped_d = 1'b1;
        end else begin
          wr_state_d = WR_DROP;
        end
      end else begin
        mem_we    = 1'b1;
        wr_addr_d = wr_addr_q + c_PTR_ONE;
        if (WrEop) begin
          wr_commit_d  = wr_addr_q + c_PTR_ONE;
          wr_pkt_cnt_d = wr_pkt_cnt_q + c_PTR_ONE;
        end
      end
    end
    wr_level = wr_addr_q - rd_sync;
    afull_d  = 32'(wr_level) >= c_AFULL_FLAG;
  end

  // Write-domain registers.
  always_ff @(posedge WrClock or posedge Reset) begin
    if (Reset) begin
      wr_state_q   <= WR_ACCEPT;
      wr_addr_q    <= '0;
      wr_commit_q  <= '0;
      wr_pkt_cnt_q <= '0;
      wr_dropped_q <= 1'b0;
      afull_q      <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      wr_addr_q    <= wr_addr_d;
      wr_commit_q  <= wr_commit_d;
      wr_pkt_cnt_q <= wr_pkt_cnt_d;
      wr_dropped_q <= wr_dropped_d;
      afull_q      <= afull_d;
    end
  end

  // Storage array; the EOP flag rides along with each beat.
  always_ff @(posedge WrClock) begin
    if (mem_we) mem_q[wr_addr_q[c_ADDR_WIDTH-1:0]] <= {WrEop, Data};
  end

  // Read-side next state: only committed beats are readable.
  always_comb begin
    empty        = rd_addr_q == commit_sync;
    rd_fire      = RdEn & ~empty;
    rd_addr_d    = rd_fire ? rd_addr_q + c_PTR_ONE : rd_addr_q;
    rd_pkt_cnt_d = (qvalid_q & rd_word_q[c_DATA_WIDTH]) ? rd_pkt_cnt_q + c_PTR_ONE : rd_pkt_cnt_q;
    rd_level     = commit_sync - rd_addr_q;
    aempty_d     = 32'(rd_level) <= c_AEMPTY_FLAG;
  end

  // Read-domain registers, including the registered RAM output which holds when idle.
  always_ff @(posedge RdClock or posedge Reset) begin
    if (Reset) begin
      rd_addr_q    <= '0;
      rd_pkt_cnt_q <= '0;
      rd_word_q    <= '0;
      qvalid_q     <= 1'b0;
      aempty_q     <= 1'b1;
    end else begin
      rd_addr_q    <= rd_addr_d;
      rd_pkt_cnt_q <= rd_pkt_cnt_d;
      qvalid_q     <= rd_fire;
      aempty_q     <= aempty_d;
      if (rd_fire) rd_word_q <= mem_q[rd_addr_q[c_ADDR_WIDTH-1:0]];
    end
  end

  assign Full        = full;
  assign AlmostFull  = afull_q;
  assign WrDropped   = wr_dropped_q;
  assign Q           = rd_word_q[c_DATA_WIDTH-1:0];
  assign RdEop       = rd_word_q[c_DATA_WIDTH];
  assign QValid      = qvalid_q;
  assign Empty       = empty;
  assign AlmostEmpty = aempty_q;
  assign PktCount    = pkt_sync - rd_pkt_cnt_q;

endmodule

// File: tb/tb_async_pkt_fifo_v2.sv
// Self-checking bench for async_pkt_fifo_v2 against a queue-based packet model.
module tb_async_pkt_fifo_v2;

  localparam int DW = 10;
  localparam int AW = 4;

  logic          WrClock = 1'b0;
  logic          RdClock = 1'b0;
  logic          Reset;
  logic [DW-1:0] Data;
  logic          WrEn, WrEop, WrAbort, RdEn;
  logic          Full, AlmostFull, WrDropped, RdEop, QValid, Empty, AlmostEmpty;
  logic [DW-1:0] Q;
  logic [AW:0]   PktCount;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] pend_q[$];
  logic        writer_done;

  async_pkt_fifo_v2 #(
    .c_DATA_WIDTH(DW), .c_ADDR_WIDTH(AW), .c_AFULL_FLAG(12), .c_AEMPTY_FLAG(3), .c_SYNC_STAGES(2)
  ) dut (
    .WrClock(WrClock), .RdClock(RdClock), .Reset(Reset), .Data(Data), .WrEn(WrEn), .WrEop(WrEop),
    .WrAbort(WrAbort), .Full(Full), .AlmostFull(AlmostFull), .WrDropped(WrDropped), .RdEn(RdEn),
    .Q(Q), .RdEop(RdEop), .QValid(QValid), .Empty(Empty), .AlmostEmpty(AlmostEmpty), .PktCount(PktCount)
  );

  always #5 WrClock = ~WrClock;
  always #8 RdClock = ~RdClock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr_cycle(input logic en, input logic eop, input logic abort, input logic [DW-1:0] d);
    @(negedge WrClock);
    WrEn = en; WrEop = eop; WrAbort = abort; Data = d;
    @(posedge WrClock); #1;
    WrEn = 1'b0; WrEop = 1'b0; WrAbort = 1'b0;
  endtask

  // Flow-controlled write: waits out Full, then the beat is certain to be stored.
  task automatic put(input logic [DW-1:0] d, input logic eop);
    int budget;
    budget = 3000;
    @(negedge WrClock);
    while (Full && budget > 0) begin
      @(negedge WrClock);
      budget--;
    end
    if (budget == 0) chk("full_stall", 32'(Full), 32'd0);
    wr_cycle(1'b1, eop, 1'b0, d);
    pend_q.push_back({eop, d});
    if (eop) begin
      foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      pend_q.delete();
    end
  endtask

  task automatic abort_pkt(input string tag);
    logic had;
    had = pend_q.size() != 0;
    wr_cycle(1'b0, 1'b0, 1'b1, '0);
    chk(tag, 32'(WrDropped), 32'(had));
    pend_q.delete();
  endtask

  task automatic rd_wait(input int n);
    repeat (n) @(posedge RdClock);
    #1;
  endtask

  task automatic rd_drain(input string tag);
    int budget;
    logic [DW:0] e;
    budget = 600;
    @(posedge RdClock); #1;
    RdEn = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge RdClock); #1;
      budget--;
      if (QValid) begin
        e = exp_q.pop_front();
        chk({tag, "_data"}, 32'(Q), 32'(e[DW-1:0]));
        chk({tag, "_eop"}, 32'(RdEop), 32'(e[DW]));
      end
    end
    RdEn = 1'b0;
    if (exp_q.size() > 0) chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge RdClock); #1;
    chk({tag, "_no_extra"}, 32'(QValid), 32'd0);
  endtask

  initial begin
    int bad;
    Reset = 1'b1; WrEn = 1'b0; WrEop = 1'b0; WrAbort = 1'b0; RdEn = 1'b0; Data = '0;
    writer_done = 1'b0;
    repeat (3) @(posedge WrClock);
    #1;
    chk("rst_full", 32'(Full), 0);
    chk("rst_afull", 32'(AlmostFull), 0);
    chk("rst_dropped", 32'(WrDropped), 0);
    chk("rst_empty", 32'(Empty), 1);
    chk("rst_aempty", 32'(AlmostEmpty), 1);
    chk("rst_qvalid", 32'(QValid), 0);
    chk("rst_q", 32'(Q), 0);
    chk("rst_rdeop", 32'(RdEop), 0);
    chk("rst_pktcnt", 32'(PktCount), 0);
    @(negedge WrClock);
    Reset = 1'b0;

    // Two packets: 3 beats then 1 beat.
    put(10'h101, 1'b0); put(10'h102, 1'b0); put(10'h103, 1'b1);
    put(10'h204, 1'b1);
    rd_wait(8);
    chk("t1_pktcnt2", 32'(PktCount), 2);
    chk("t1_not_empty", 32'(Empty), 0);
    chk("t1_aempty", 32'(AlmostEmpty), 0);
    rd_drain("t1");
    rd_wait(6);
    chk("t1_empty_after", 32'(Empty), 1);
    chk("t1_pktcnt0", 32'(PktCount), 0);
    chk("t1_aempty_after", 32'(AlmostEmpty), 1);

    // Uncommitted beats must stay invisible.
    for (int i = 0; i < 5; i++) put(DW'(10'h300 + i), 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge RdClock); #1;
      if (!Empty) bad++;
    end
    chk("t2_empty_held", 32'(bad), 0);
    put(10'h3ff, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge RdClock); #1;
      if (!Empty) break;
    end
    chk("t2_visible", 32'(Empty), 0);
    rd_drain("t2");
    rd_wait(6);

    // Overflow with EOP on the first rejected beat.
    for (int i = 0; i < 16; i++) begin
      wr_cycle(1'b1, 1'b0, 1'b0, DW'(i));
      if (i == 14) chk("t3_not_full15", 32'(Full), 0);
    end
    chk("t3_full16", 32'(Full), 1);
    chk("t3_afull16", 32'(AlmostFull), 1);
    wr_cycle(1'b1, 1'b1, 1'b0, 10'h3aa);
    chk("t3_dropped", 32'(WrDropped), 1);
    chk("t3_full_cleared", 32'(Full), 0);
    wr_cycle(1'b0, 1'b0, 1'b0, '0);
    chk("t3_dropped_pulse", 32'(WrDropped), 0);
    rd_wait(6);
    chk("t3_empty", 32'(Empty), 1);
    chk("t3_pktcnt0", 32'(PktCount), 0);
    // Overflow mid-packet: drop lasts until EOP.
    for (int i = 0; i < 16; i++) wr_cycle(1'b1, 1'b0, 1'b0, DW'(i + 32));
    wr_cycle(1'b1, 1'b0, 1'b0, 10'h155);
    chk("t3b_no_drop_yet", 32'(WrDropped), 0);
    wr_cycle(1'b1, 1'b0, 1'b0, 10'h156);
    chk("t3b_still_dropping", 32'(WrDropped), 0);
    wr_cycle(1'b1, 1'b1, 1'b0, 10'h157);
    chk("t3b_dropped", 32'(WrDropped), 1);
    chk("t3b_full_cleared", 32'(Full), 0);
    put(10'h0a1, 1'b1);
    put(10'h0b1, 1'b0); put(10'h0b2, 1'b1);
    rd_drain("t3b");
    rd_wait(6);

    // Abort handling.
    for (int i = 0; i < 4; i++) put(DW'(10'h2a0 + i), i == 3);
    for (int i = 0; i < 3; i++) put(DW'(10'h2b0 + i), 1'b0);
    abort_pkt("t4_abort_b");
    abort_pkt("t4_abort_noop");
    put(10'h2d0, 1'b0); put(10'h2d1, 1'b0);
    wr_cycle(1'b1, 1'b1, 1'b1, 10'h2d2);
    chk("t4_abort_wins", 32'(WrDropped), 1);
    pend_q.delete();
    put(10'h2c0, 1'b0); put(10'h2c1, 1'b1);
    rd_wait(8);
    chk("t4_pktcnt2", 32'(PktCount), 2);
    rd_drain("t4");
    rd_wait(6);
    chk("t4_pktcnt0", 32'(PktCount), 0);

    // Random streaming with random reader back-pressure.
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge WrClock);
          put(DW'($urandom), 1'b1);
        end
        for (int p = 0; p < 40; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) begin
            if (b == len - 1 && $urandom_range(0, 99) < 15) begin
              abort_pkt("t5_abort");
            end else begin
              put(DW'($urandom), b == len - 1);
            end
          end
        end
        writer_done = 1'b1;
      end
      begin
        int budget;
        logic [DW:0] e;
        budget = 20000;
        while (!(writer_done && exp_q.size() == 0) && budget > 0) begin
          @(posedge RdClock); #1;
          budget--;
          if (QValid) begin
            if (exp_q.size() == 0) begin
              chk("t5_extra_beat", 32'(QValid), 0);
            end else begin
              e = exp_q.pop_front();
              chk("t5_data", 32'(Q), 32'(e[DW-1:0]));
              chk("t5_eop", 32'(RdEop), 32'(e[DW]));
            end
          end
          RdEn = 1'($urandom_range(0, 1));
        end
        if (budget == 0) chk("t5_timeout", 32'(exp_q.size()), 0);
        RdEn = 1'b0;
        @(posedge RdClock); #1;
        chk("t5_no_extra", 32'(QValid), 0);
      end
    join
    rd_wait(6);
    chk("t5_empty", 32'(Empty), 1);
    chk("t5_pktcnt0", 32'(PktCount), 0);

    // Reset with committed and uncommitted beats resident.
    for (int i = 0; i < 7; i++) put(DW'(10'h1c0 + i), i == 6);
    put(10'h1d0, 1'b0); put(10'h1d1, 1'b0);
    rd_wait(8);
    chk("t6_pre_pktcnt", 32'(PktCount), 1);
    Reset = 1'b1;
    #3;
    chk("t6_empty", 32'(Empty), 1);
    chk("t6_aempty", 32'(AlmostEmpty), 1);
    chk("t6_afull", 32'(AlmostFull), 0);
    chk("t6_pktcnt", 32'(PktCount), 0);
    chk("t6_qvalid", 32'(QValid), 0);
    rd_wait(2);
    chk("t6_empty_held", 32'(Empty), 1);
    chk("t6_pktcnt_held", 32'(PktCount), 0);
    exp_q.delete();
    pend_q.delete();
    @(negedge WrClock);
    Reset = 1'b0;
    put(10'h111, 1'b0); put(10'h222, 1'b1);
    rd_drain("t6_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
